data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, default 1024, RAM size in 32-bit words (power of two).
REQ-002 Parameter: WAIT_CYCLES, default 1, added response latency, legal range 0..15.
REQ-003 Port: clk  in  1  single clock, all state on rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: req_valid  in  1  request present.
REQ-006 Port: req_ready  out  1  responder can accept request.
REQ-007 Port: req_addr  in  32  byte address.
REQ-008 Port: req_wdata  in  32  store data, lane-positional.
REQ-009 Port: req_we  in  4  byte-lane write enables; 4'b0000 = read.
REQ-010 Port: rsp_valid  out  1  response present.
REQ-011 Port: rsp_ready  in  1  requester takes response.
REQ-012 Port: rsp_rdata  out  32  read data.
REQ-013 Port: rsp_err  out  1  request failed, no side effect.
REQ-014 Port: tohost_valid  out  1  one-cycle pulse on TOHOST write.
REQ-015 Port: tohost_data  out  32  current TOHOST register value.

Function
REQ-016 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 Accept on req_valid && req_ready; capture addr, wdata, we that edge; go WAIT (counter = WAIT_CYCLES) if WAIT_CYCLES>0, else RESP.
REQ-018 WAIT decrements counter each cycle; on the edge where counter reaches 0, go RESP.
REQ-019 rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 Write commit and read sampling SHALL occur on the edge that enters RESP; later requests observe committed data.
REQ-021 In RESP, rsp_valid, rsp_rdata, rsp_err held stable until rsp_valid && rsp_ready; that edge returns to IDLE.
REQ-022 No accept in the RESP-exit cycle (req_ready low); minimum throughput one transaction per WAIT_CYCLES+2 cycles.
REQ-023 Decode: RAM if req_addr < DEPTH_WORDS*4, index = req_addr[log2(DEPTH_WORDS)+1:2]; MMIO if req_addr[31:16]==16'hFFFF; else error.
REQ-024 req_addr[1:0] ignored; lanes positional (lane n = bits 8n+7:8n); reads return full word.
REQ-025 Legal req_we: 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111; any other value -> error.
REQ-026 Error response: rsp_err=1, rsp_rdata=0, no RAM/MMIO state change, no tohost pulse.
REQ-027 Non-error response: rsp_err=0; writes return rsp_rdata = word value after merge.
REQ-028 MMIO 0xFFFF0000 CYCLE: read-only free-running counter, +1 every clk, wraps 0xFFFFFFFF->0; write -> error.
REQ-029 MMIO 0xFFFF0004 SCRATCH: read/write, byte-lane merge.
REQ-030 MMIO 0xFFFF0008 TOHOST: byte-lane merge into tohost_data; tohost_valid high exactly the cycle after the commit edge; reads return tohost_data.
REQ-031 Other MMIO offsets -> error.
REQ-032 CYCLE read returns counter value sampled at commit edge.

Reset
REQ-033 rst_n low asynchronously forces IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, tohost_valid=0, tohost_data=0, SCRATCH=0, CYCLE=0.
REQ-034 Reset mid-transaction discards the pending request; an uncommitted write SHALL NOT reach RAM/MMIO.
REQ-035 RAM contents not reset; undefined until written.
REQ-036 First accept possible on first rising edge after rst_n deasserts.

Verification
REQ-037 WAIT_CYCLES=1: write 0x0000_0010 we=1111 data 0xDEADBEEF, then read 0x10 -> rsp_valid 2 cycles after each accept, read rdata 0xDEADBEEF, err 0.
REQ-038 Byte merge: after REQ-037, write 0x10 we=0010 data 0x0000_5500 -> read 0x10 returns 0xDEAD55EF.
REQ-039 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0 throughout, IDLE one cycle after handshake.
REQ-040 Errors: read 0x8000_0000, write CYCLE, we=0101 -> each rsp_err=1, rdata 0, RAM unchanged.
REQ-041 TOHOST: write 0xFFFF0008 we=1111 data 1 -> tohost_data=1, tohost_valid single-cycle pulse; subsequent read returns 1.
REQ-042 Reset: assert rst_n low in WAIT of a write to 0x20 -> no rsp_valid, outputs at reset values immediately; later read 0x20 returns prior contents.

Source files
------------

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Single-outstanding data memory responder with RAM and MMIO.
//  Revision    : 1.0
// ============================================================================
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_we,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        tohost_valid,
   output logic [31:0] tohost_data
);

   localparam int          c_idx_w     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] c_ram_bytes = 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [3:0]  c_wait      = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [31:0]  addr_q, wdata_q;
   logic [3:0]   we_q;
   logic [31:0]  rsp_rdata_q, cycle_q, scratch_q, tohost_q;
   logic         rsp_err_q, tohost_valid_q;
   logic [31:0]  mem_q [DEPTH_WORDS];

   logic                w_take, w_commit;
   logic [31:0]         w_addr, w_wdata;
   logic [3:0]          w_we;
   logic [c_idx_w-1:0]  w_idx;
   logic                w_is_ram, w_is_mmio;
   logic [13:0]         w_off;
   logic                w_we_ok, w_dec_err, w_err, w_wr;
   logic [31:0]         w_old, w_merged;

   // With WAIT_CYCLES=0 the commit edge is the accept edge, so the live
   // request is used; otherwise the captured copy is.
   assign w_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
   assign w_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
   assign w_we    = (state_q == S_IDLE) ? req_we    : we_q;

   assign w_take   = req_valid && (state_q == S_IDLE);
   assign w_commit = (state_d == S_RESP) && (state_q != S_RESP);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (c_wait == 4'd0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = c_wait;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign w_idx     = w_addr[c_idx_w+1:2];
   assign w_is_ram  = {1'b0, w_addr} < c_ram_bytes;
   assign w_is_mmio = (w_addr[31:16] == 16'hFFFF);
   assign w_off     = w_addr[15:2];

   always_comb begin
      w_we_ok   = 1'b0;
      w_old     = '0;
      w_dec_err = 1'b0;
      case (w_we)
         4'b0000, 4'b0001, 4'b0010, 4'b0100,
         4'b1000, 4'b0011, 4'b1100, 4'b1111: w_we_ok = 1'b1;
         default: w_we_ok = 1'b0;
      endcase
      if (w_is_ram) begin
         w_old = mem_q[w_idx];
      end else if (w_is_mmio) begin
         case (w_off)
            14'd0: begin
               w_old     = cycle_q;
               w_dec_err = |w_we;
            end
            14'd1:   w_old = scratch_q;
            14'd2:   w_old = tohost_q;
            default: w_dec_err = 1'b1;
         endcase
      end else begin
         w_dec_err = 1'b1;
      end
      w_err = w_dec_err | ~w_we_ok;
   end

   for (genvar n = 0; n < 4; n++) begin : g_lane
      assign w_merged[8*n +: 8] = w_we[n] ? w_wdata[8*n +: 8] : w_old[8*n +: 8];
   end

   // rst_n gate keeps a request presented during reset from landing in RAM.
   assign w_wr = w_commit && !w_err && (|w_we) && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         addr_q         <= '0;
         wdata_q        <= '0;
         we_q           <= '0;
         rsp_rdata_q    <= '0;
         rsp_err_q      <= 1'b0;
         cycle_q        <= '0;
         scratch_q      <= '0;
         tohost_q       <= '0;
         tohost_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         cycle_q        <= cycle_q + 32'd1;
         tohost_valid_q <= 1'b0;
         if (w_take) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
         end
         if (w_commit) begin
            rsp_rdata_q <= w_err ? 32'd0 : w_merged;
            rsp_err_q   <= w_err;
         end
         if (w_wr && !w_is_ram && w_is_mmio && (w_off == 14'd1)) begin
            scratch_q <= w_merged;
         end
         if (w_wr && !w_is_ram && w_is_mmio && (w_off == 14'd2)) begin
            tohost_q       <= w_merged;
            tohost_valid_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr && w_is_ram) begin
         mem_q[w_idx] <= w_merged;
      end
   end

   assign rsp_rdata    = rsp_rdata_q;
   assign rsp_err      = rsp_err_q;
   assign tohost_valid = tohost_valid_q;
   assign tohost_data  = tohost_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Scoreboard bench for data_mem_responder with a memory-map model.
//  Revision    : 1.0
// ============================================================================
module tb_data_mem_responder;

   localparam int DEPTH = 1024;
   localparam int WAITC = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_we = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        tohost_valid;
   logic [31:0] tohost_data;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .tohost_valid(tohost_valid), .tohost_data(tohost_data)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int ecount = 0;
   int rel_base = 0;
   int pulse_edge = -1;

   always @(posedge clk) ecount <= ecount + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
      int          hold;
      string       name;
   } exp_t;
   exp_t sb[$];

   logic [31:0] ram_m [DEPTH];
   bit          known [DEPTH];
   logic [31:0] scratch_m = '0;
   logic [31:0] tohost_m = '0;
   int          pool[$];

   logic [3:0]  legal_we [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                 4'b1000, 4'b0011, 4'b1100, 4'b1111};
   logic [3:0]  bad_we   [8] = '{4'b0101, 4'b0110, 4'b0111, 4'b1001,
                                 4'b1010, 4'b1011, 4'b1101, 4'b1110};
   logic [31:0] bad_addr [5] = '{32'(DEPTH*4), 32'h8000_0000, 32'hFFFF_000C,
                                 32'hFFFE_0004, 32'h7FFF_FFFC};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] we);
      logic [31:0] r;
      r = old;
      for (int n = 0; n < 4; n++) if (we[n]) r[8*n +: 8] = wd[8*n +: 8];
      return r;
   endfunction

   // Monitor: compares every presented response against the scoreboard head.
   bit seen = 0;
   bit expect_idle = 0;
   int hold_left = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         rsp_ready   = 1'b0;
         seen        = 0;
         expect_idle = 0;
      end else begin
         check("tohost_valid", 32'(tohost_valid), 32'(pulse_edge == ecount));
         if (expect_idle) begin
            check("idle_after_handshake", {30'd0, rsp_valid, req_ready}, 32'd1);
            expect_idle = 0;
         end
         if (rsp_valid) begin
            check("req_ready_in_resp", 32'(req_ready), 32'd0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: rsp_valid=1 required 0");
            end else begin
               if (!seen) begin
                  check({sb[0].name, "_latency"}, 32'(ecount + 1 - sb[0].acc), 32'(WAITC + 1));
                  hold_left = sb[0].hold;
                  seen = 1;
               end
               check({sb[0].name, "_rdata"}, rsp_rdata, sb[0].rdata);
               check({sb[0].name, "_err"}, 32'(rsp_err), 32'(sb[0].err));
               if (hold_left > 0) begin
                  rsp_ready = 1'b0;
                  hold_left--;
               end else begin
                  rsp_ready = 1'b1;
                  void'(sb.pop_front());
                  seen = 0;
                  expect_idle = 1;
               end
            end
         end else begin
            rsp_ready = 1'b0;
         end
      end
   end

   // Called at a negedge; returns at the negedge following the accept edge.
   task automatic issue(input string name, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] we, input int hold_n);
      exp_t        e;
      logic [31:0] old;
      logic [31:0] word;
      bit          err;
      int          guard;
      int          acc;
      guard = 0;
      while (!req_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL %s_accept_timeout: req_ready=%0b required 1", name, req_ready);
         return;
      end
      acc  = ecount + 1;
      err  = !(we inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
      old  = '0;
      word = addr & ~32'h3;
      if (!err) begin
         if (addr < 32'(DEPTH*4)) old = ram_m[int'(addr >> 2)];
         else if (word == 32'hFFFF_0000) begin
            if (we != 4'b0000) err = 1;
            else old = 32'(acc + WAITC - 1 - rel_base);
         end
         else if (word == 32'hFFFF_0004) old = scratch_m;
         else if (word == 32'hFFFF_0008) old = tohost_m;
         else err = 1;
      end
      e.rdata = err ? 32'd0 : merge(old, wd, we);
      e.err   = err;
      e.acc   = acc;
      e.hold  = hold_n;
      e.name  = name;
      if (!err && we != 4'b0000) begin
         if (addr < 32'(DEPTH*4)) begin
            ram_m[int'(addr >> 2)] = e.rdata;
            known[int'(addr >> 2)] = 1;
         end
         else if (word == 32'hFFFF_0004) scratch_m = e.rdata;
         else begin
            tohost_m   = e.rdata;
            pulse_edge = acc + WAITC;
         end
      end
      sb.push_back(e);
      req_valid = 1'b1;
      req_addr  = addr;
      req_wdata = wd;
      req_we    = we;
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_we    = 4'($urandom);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((sb.size() != 0 || !req_ready) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: pending=%0d required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic apply_reset();
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      sb.delete();
      pulse_edge = -1;
      scratch_m  = '0;
      tohost_m   = '0;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_tohost_valid", 32'(tohost_valid), 32'd0);
      check("rst_tohost_data", tohost_data, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      rel_base = ecount;
   endtask

   task automatic random_phase(input int n_ops);
      int          k;
      int          idx;
      logic [3:0]  we;
      logic [31:0] wd;
      logic [31:0] lo;
      int          hold_n;
      for (int t = 0; t < n_ops; t++) begin
         k      = $urandom_range(0, 9);
         we     = legal_we[$urandom_range(0, 7)];
         wd     = $urandom;
         lo     = 32'($urandom_range(0, 3));
         idx    = pool[$urandom_range(0, pool.size() - 1)];
         hold_n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         case (k)
            0, 1, 2: issue("rnd_ram", 32'(idx * 4) | lo, wd, we, hold_n);
            3:       issue("rnd_scratch", 32'hFFFF_0004 | lo, wd, we, hold_n);
            4:       issue("rnd_tohost", 32'hFFFF_0008 | lo, wd, we, hold_n);
            5:       issue("rnd_cycle_rd", 32'hFFFF_0000 | lo, wd, 4'b0000, hold_n);
            6:       issue("rnd_cycle_wr", 32'hFFFF_0000, wd, legal_we[$urandom_range(1, 7)], hold_n);
            7:       issue("rnd_bad_we", 32'(idx * 4), wd, bad_we[$urandom_range(0, 7)], hold_n);
            8:       issue("rnd_bad_addr", bad_addr[$urandom_range(0, 4)], wd, we, hold_n);
            default: issue("rnd_ram_rd", 32'(idx * 4) | lo, wd, 4'b0000, hold_n);
         endcase
         if ((t % 25) == 24) begin
            drain();
            check("rnd_tohost_data", tohost_data, tohost_m);
         end
      end
   endtask

   initial begin
      logic [31:0] saved;
      #2;
      apply_reset();

      issue("wr_full", 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 0);
      issue("rd_full", 32'h0000_0010, 32'h0, 4'b0000, 0);
      issue("wr_lane1", 32'h0000_0010, 32'h0000_5500, 4'b0010, 0);
      issue("rd_merge", 32'h0000_0010, 32'h0, 4'b0000, 0);
      issue("rd_backpressure", 32'h0000_0011, 32'h0, 4'b0000, 5);
      issue("err_range", 32'h8000_0000, 32'h0, 4'b0000, 0);
      issue("err_cycle_wr", 32'hFFFF_0000, 32'h1234_5678, 4'b1111, 0);
      issue("err_we0101", 32'h0000_0010, 32'hFFFF_FFFF, 4'b0101, 0);
      issue("rd_after_err", 32'h0000_0010, 32'h0, 4'b0000, 0);
      issue("err_past_end", 32'(DEPTH*4), 32'h0, 4'b0000, 0);
      issue("wr_last_word", 32'(DEPTH*4 - 4), 32'hA5A5_5A5A, 4'b1100, 0);
      issue("wr_tohost", 32'hFFFF_0008, 32'h0000_0001, 4'b1111, 0);
      drain();
      check("tohost_data_after_wr", tohost_data, tohost_m);
      issue("rd_tohost", 32'hFFFF_0008, 32'h0, 4'b0000, 0);
      issue("wr_scratch", 32'hFFFF_0004, 32'hCAFE_F00D, 4'b0011, 1);
      issue("rd_scratch", 32'hFFFF_0004, 32'h0, 4'b0000, 0);
      issue("rd_cycle", 32'hFFFF_0000, 32'h0, 4'b0000, 0);
      issue("err_mmio_off", 32'hFFFF_000C, 32'h0, 4'b0000, 0);

      issue("wr_0x20", 32'h0000_0020, 32'h1357_9BDF, 4'b1111, 0);
      drain();
      saved = ram_m[8];
      issue("wr_0x20_discard", 32'h0000_0020, 32'hFFFF_0000, 4'b1111, 0);
      ram_m[8] = saved;
      apply_reset();
      issue("rd_0x20_after_rst", 32'h0000_0020, 32'h0, 4'b0000, 0);
      issue("rd_scratch_after_rst", 32'hFFFF_0004, 32'h0, 4'b0000, 0);
      issue("rd_tohost_after_rst", 32'hFFFF_0008, 32'h0, 4'b0000, 0);
      issue("rd_cycle_after_rst", 32'hFFFF_0000, 32'h0, 4'b0000, 0);

      for (int i = 0; i < 16; i++) pool.push_back(i);
      pool.push_back(DEPTH - 1);
      foreach (pool[i]) issue("init_ram", 32'(pool[i] * 4), $urandom, 4'b1111, 0);
      random_phase(300);
      drain();
      check("final_tohost_data", tohost_data, tohost_m);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
